div_unit: RTL and testbench

Multi-cycle divider and sequencer for the HI/LO datapath. It accepts a DIV/DIVU request from the execute stage and holds the pipeline with a stall request while it iterates. It then presents a 64-bit {remainder, quotient} result; execute forwards this through the memory and write-back registers as hi/lo with whilo set. It runs one restoring shift-subtract step per cycle and supports annulment when the divide sits in a squashed delay slot or exception path.

---
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the HI/LO datapath: one shift-subtract step per clock,
// signed/unsigned, divide-by-zero short path, annul and execute-stage stall request.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);
    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic        r_sign1;
    logic        r_sign2;
    logic [63:0] r_result;
    logic        r_ready;

    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    always_comb begin
        // ~cnt[4:0] == 31-cnt: dividend bits enter MSB first
        w_rem_sh  = {r_rem, r_dividend[~r_cnt[4:0]]};
        w_diff    = w_rem_sh - {1'b0, r_divisor};
        // a set top bit on the shifted remainder already exceeds any 32-bit divisor
        w_ge      = w_rem_sh[32] | ~w_diff[32];
        w_quo_fix = (r_sign1 ^ r_sign2) ? (32'd0 - r_quo) : r_quo;
        w_rem_fix = r_sign1 ? (32'd0 - r_rem) : r_rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FREE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= S_BYZERO;
                        end else begin
                            r_state    <= S_ON;
                            r_dividend <= (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
                            r_divisor  <= (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
                            r_sign1    <= signed_div_i & opdata1_i[31];
                            r_sign2    <= signed_div_i & opdata2_i[31];
                            r_cnt      <= '0;
                            r_rem      <= '0;
                            r_quo      <= '0;
                        end
                    end
                end
                S_BYZERO: begin
                    r_state  <= S_END;
                    r_result <= '0;
                    r_ready  <= 1'b1;
                end
                S_ON: begin
                    if (annul_i) begin
                        r_state  <= S_FREE;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else if (!r_cnt[5]) begin
                        r_rem <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
                        r_quo <= {r_quo[30:0], w_ge};
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_state  <= S_FREE;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: r_state <= S_FREE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        if (!annul_i) begin
            stallreq_o = (r_state == S_ON) || (r_state == S_BYZERO) ||
                         ((r_state == S_FREE) && start_i);
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corners plus random operands against an arithmetic model.
module tb_div_unit;
    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: C-style truncating division on 64-bit integers, low 32 bits kept.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          edges;
        logic        stall_ok;
        exp = ref_div(sgn, a, b);
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        #1 check("stall_req", {63'd0, stallreq_o}, 64'd1);
        edges    = 0;
        stall_ok = 1'b1;
        while (!ready_o && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (!ready_o && !stallreq_o) stall_ok = 1'b0;
        end
        check("latency", 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
        check("result", result_o, exp);
        check("stall_hold", {63'd0, stall_ok}, 64'd1);
        check("stall_ready", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        check("end_hold_rdy", {63'd0, ready_o}, 64'd1);
        check("end_hold_res", result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("ready_clr", {63'd0, ready_o}, 64'd0);
        check("result_clr", result_o, 64'd0);
    endtask

    initial begin
        logic        ready_seen;
        logic [31:0] a, b;
        logic        sgn;
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall", {63'd0, stallreq_o}, 64'd0);
        check("rst_cnt", {58'd0, dut.r_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div(1'b0, 32'd100, 32'd7);
        check("divu_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFFFFF9, 32'd2);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_div(1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_div(1'b1, 32'h12345678, 32'd0);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1);

        // Annul with cnt == 10
        @(negedge clk);
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1 check("annul_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        check("annul_result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        #1 check("annul_free_stall", {63'd0, stallreq_o}, 64'd0);
        ready_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o || result_o != 64'd0) ready_seen = 1'b1;
        end
        check("annul_no_ready", {63'd0, ready_seen}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3);

        // Asynchronous reset with cnt == 15
        @(negedge clk);
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'h1234;
        repeat (16) @(posedge clk);
        #1 check("pre_rst_cnt", {58'd0, dut.r_cnt}, 64'd15);
        #2 rst = 1'b0;
        #1;
        check("arst_ready", {63'd0, ready_o}, 64'd0);
        check("arst_result", result_o, 64'd0);
        check("arst_cnt", {58'd0, dut.r_cnt}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div(1'b1, 32'hDEADBEEF, 32'h1234);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'h80000000;
                1:       a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
            run_div(sgn, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
